// File: rtl/l2_cache_arb_stage.sv
// L2 cache arbitration stage.
// Selects one request per cycle for the tag stage: a restarted request from
// the fill path always wins; otherwise, when the miss queue is not stalling,
// one core port is chosen round-robin and dequeued via l2_ready.
// Outputs toward the tag stage are registered (1-cycle latency).
// Optional build macro: L2_ARB_PERF_EVENTS_EN enables the two perf-event pulses.
//
// Handshake: a core port is dequeued in the cycle where both its
// l2i_request_valid and l2_ready are 1; a port may drop valid without having
// been granted. The restart path has no ready: it is accepted whenever valid.

package l2_cache_arb_pkg;
  localparam int LINE_BITS = 512;

  typedef logic [LINE_BITS-1:0] cache_line_data_t;

  typedef struct packed {
    logic [3:0]  cache_op;
    logic [3:0]  id;
    logic [31:0] address;
  } l2req_packet_t;
endpackage

module l2_cache_arb_stage
  import l2_cache_arb_pkg::*;
#(
  parameter int NUM_PORTS = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_PORTS-1:0] l2i_request_valid,
  input  l2req_packet_t        l2i_request [NUM_PORTS],
  output logic [NUM_PORTS-1:0] l2_ready,
  input  logic                 l2bi_request_valid,
  input  l2req_packet_t        l2bi_request,
  input  cache_line_data_t     l2bi_data_from_memory,
  input  logic                 l2bi_is_restarted_flush,
  input  logic                 l2bi_stall,
  output logic                 l2a_request_valid,
  output l2req_packet_t        l2a_request,
  output cache_line_data_t     l2a_data_from_memory,
  output logic                 l2a_is_l2_fill,
  output logic                 l2a_is_restarted_flush,
  output logic [1:0]           l2a_perf_events
);

  localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [PTR_W-1:0] rr_q, rr_d;
  logic [PTR_W-1:0] winner;
  logic [PTR_W-1:0] idx;
  logic             any_valid;
  logic             core_grant;
  logic             restart_grant;

  // Round-robin search starting at rr_q; index wraps naturally (power of two).
  always_comb begin
    any_valid = 1'b0;
    winner    = rr_q;
    idx       = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      idx = rr_q + PTR_W'(i);
      if (!any_valid && l2i_request_valid[idx]) begin
        any_valid = 1'b1;
        winner    = idx;
      end
    end
  end

  assign restart_grant = l2bi_request_valid;
  assign core_grant    = any_valid && !l2bi_request_valid && !l2bi_stall;

  // Dequeue strobe to the winning core port; forced low while in reset.
  always_comb begin
    l2_ready = '0;
    if (core_grant && reset_n) begin
      l2_ready[winner] = 1'b1;
    end
  end

  // Pointer advances past the winner on core grants only.
  always_comb begin
    rr_d = rr_q;
    if (core_grant) begin
      rr_d = winner + PTR_W'(1);
    end
  end

  // Reset-cleared control state: pointer, valid and request-kind flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_q                   <= '0;
      l2a_request_valid      <= 1'b0;
      l2a_is_l2_fill         <= 1'b0;
      l2a_is_restarted_flush <= 1'b0;
    end else begin
      rr_q                   <= rr_d;
      l2a_request_valid      <= restart_grant || core_grant;
      l2a_is_l2_fill         <= restart_grant && !l2bi_is_restarted_flush;
      l2a_is_restarted_flush <= restart_grant && l2bi_is_restarted_flush;
    end
  end

  // Payload registers are not reset; they are meaningful only with valid=1.
  always_ff @(posedge clk) begin
    if (restart_grant) begin
      l2a_request          <= l2bi_request;
      l2a_data_from_memory <= l2bi_data_from_memory;
    end else if (core_grant) begin
      l2a_request          <= l2i_request[winner];
    end
  end

`ifdef L2_ARB_PERF_EVENTS_EN
  logic [1:0] perf_q;

  // One-cycle pulses: [0] core grant, [1] core request held off by stall.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_q <= 2'b00;
    end else begin
      perf_q[0] <= core_grant;
      perf_q[1] <= any_valid && l2bi_stall && !l2bi_request_valid;
    end
  end

  assign l2a_perf_events = perf_q;
`else
  assign l2a_perf_events = 2'b00;
`endif

endmodule
